pll_lock_ctrl: RTL
==================

Name: pll_lock_ctrl

Overview:
- Reset and lock sequencer for the DDR PLL wrapper (50 MHz in; 400/50/100/… MHz out). Sits directly upstream of the PLL instance.
- Drives the PLL reset and the clkout0 gate, and monitors the PLL lock.
- Runs on the 50 MHz reference clock, the same net as the PLL clkin1.
- Opens the clkout0 gate only after lock has been stable, retries on lock timeout, and reports ready, fail and lock-loss status to the DDR init logic.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high after rst deasserts or on each retry; minimum 2.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry.
- LOCK_STABLE, 1024: consecutive synced-lock cycles required before the gate opens.
- GATE_DELAY, 8: cycles between gate open and ready.
- MAX_RETRY, 3: retries allowed before FAIL.
- CNT_W, 8: width of the status counters.

Ports:
- clk  in  1  50 MHz reference clock.
- rst  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock; asynchronous to clk.
- pll_rst  out  1  PLL reset, active-high.
- clkout0_gate  out  1  1 = clkout0 enabled (gate open).
- ready  out  1  PLL locked, stable, and gate open.
- fail  out  1  retry budget exhausted; sticky until rst.
- retry_cnt  out  CNT_W  timeouts since the last successful lock.
- loss_cnt  out  CNT_W  lock losses after ready, saturating.

Behaviour:
- Reset: rst is sampled on the clk edge. While rst=1, all state is forced as follows:
  - state=RST_HOLD, cnt=0;
  - pll_rst=1, clkout0_gate=0, ready=0, fail=0;
  - retry_cnt=0, loss_cnt=0.
- rst mid-operation overrides every state on the next edge, including FAIL.
- Synchroniser: pll_lock passes through 2 flops to give lock_s. Latency is 2 cycles; lock_s is the only lock signal the FSM uses.
- Output timing: all outputs are registered and decoded from the state register, so they change on the same edge as the state.
- Single counter cnt: width is clog2 of the largest of the period parameters. It clears on every state change.
- RST_HOLD:
  - Outputs: pll_rst=1, gate=0, ready=0.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - Outputs: pll_rst=0.
  - If lock_s=1, go to STABLE.
  - Else, when cnt==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - else retry_cnt++ and go to RST_HOLD.
  - If lock_s rises on the timeout cycle, lock wins.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK with cnt=0. This is not a retry.
  - When cnt==LOCK_STABLE-1 with lock_s=1, go to GATE_ON.
- GATE_ON:
  - Outputs: clkout0_gate=1.
  - When cnt==GATE_DELAY-1, go to RUN.
- RUN:
  - Outputs: clkout0_gate=1, ready=1.
  - retry_cnt clears on entry.
- Lock loss in GATE_ON or RUN (lock_s=0):
  - Next edge: gate=0, ready=0, state=RST_HOLD.
  - loss_cnt++, saturating at 2^CNT_W-1. retry_cnt is not changed.
- FAIL:
  - Outputs: pll_rst=1, gate=0, ready=0, fail=1.
  - Terminal; exit only via rst.
- Timing:
  - rst falling → pll_rst low after exactly RST_CYCLES edges.
  - pll_lock rise in WAIT_LOCK → STABLE 3 edges later.
  - ready rises LOCK_STABLE+GATE_DELAY edges after STABLE entry.
- Invariants:
  - ready=1 implies clkout0_gate=1.
  - clkout0_gate=1 implies pll_rst=0.
  - pll_rst and clkout0_gate are never both 1.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the state enum (RST_HOLD, WAIT_LOCK, STABLE, GATE_ON, RUN, FAIL), 3-bit encoding;
  - default parameter constants;
  - a clog2-based counter width function.
- One sub-module, pll_lock_sync: a generic 2-flop synchroniser. It has no reset (the synchroniser flops carry none) and is reused later for other async status inputs.
- FSM, counter and outputs live in pll_lock_ctrl.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, GATE_DELAY=2, MAX_RETRY=2, CNT_W=4.
1. Nominal: rst high 3 cycles then low; pll_lock rises 10 cycles after pll_rst falls.
   → pll_rst high exactly 4 cycles after rst falls; STABLE entered 3 cycles after the lock rise; gate opens 8 cycles later; ready 2 cycles after that; retry_cnt=0, fail=0.
2. Timeout/retry: pll_lock held 0.
   → pll_rst pulses of 4 cycles separated by 32-cycle windows; retry_cnt steps 1, 2; after the third timeout fail=1 and pll_rst stays 1 permanently.
3. Late recovery: lock arrives in the window after 1 retry.
   → ready asserts; retry_cnt returns to 0 on RUN entry.
4. Glitch in STABLE: lock drops for 1 cycle at cnt=5.
   → back to WAIT_LOCK with no pll_rst pulse; full 8-cycle stability restarts; gate stays 0 throughout.
5. Loss after ready: drop pll_lock in RUN.
   → 2 cycles of sync latency, then on the next edge gate=0, ready=0, pll_rst=1, loss_cnt=1; relocking gives ready again. Repeat 20 times → loss_cnt saturates at 15.
6. rst asserted in FAIL and in RUN.
   → next edge: all outputs at reset values, counters 0; a normal sequence follows; the pll_rst/gate invariants are checked by assertion on every cycle.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared definitions for the DDR PLL reset/lock sequencer.
//   - pll_state_e  : sequencer state, 3-bit encoding (also exported for debug)
//   - pll_outs_t   : the registered output bundle decoded from a state
//   - DEF_*        : default parameter values
//   - cnt_width()  : width of the single period counter
//   - state_outs() : output decode for a given state
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        GATE_ON   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_e;

    typedef struct packed {
        logic pll_rst;
        logic clkout0_gate;
        logic ready;
        logic fail;
    } pll_outs_t;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_LOCK_TIMEOUT = 65536;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_GATE_DELAY   = 8;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_CNT_W        = 8;

    // The counter only ever needs to reach (period - 1) of the longest period,
    // so clog2 of that period is enough bits.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic pll_outs_t state_outs(input pll_state_e s);
        pll_outs_t o;
        o = '0;
        case (s)
            RST_HOLD: o.pll_rst = 1'b1;
            GATE_ON:  o.clkout0_gate = 1'b1;
            RUN: begin
                o.clkout0_gate = 1'b1;
                o.ready        = 1'b1;
            end
            FAIL: begin
                o.pll_rst = 1'b1;
                o.fail    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if: bundle between the lock sequencer, the PLL instance and
// the DDR init logic.
//   pll_lock      PLL lock, asynchronous to clk (from the PLL)
//   pll_rst       PLL reset, active-high
//   clkout0_gate  1 = clkout0 enabled
//   ready         PLL locked, stable and gate open
//   fail          retry budget exhausted, sticky until rst
//   retry_cnt     timeouts since last successful lock
//   loss_cnt      lock losses after ready, saturating
//   state         sequencer state, for debug/checkers
// There is no valid/ready handshake here: every signal is a level that the
// consumer may sample on any clk edge; "ready" is a status, not a strobe.
interface pll_lock_ctrl_if #(parameter int CNT_W = 8);
    import pll_ctrl_pkg::*;

    logic             pll_lock;
    logic             pll_rst;
    logic             clkout0_gate;
    logic             ready;
    logic             fail;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;
    pll_state_e       state;

    // master: the sequencer
    modport master (
        input  pll_lock,
        output pll_rst, clkout0_gate, ready, fail, retry_cnt, loss_cnt, state
    );

    // slave: the PLL / DDR init side
    modport slave (
        output pll_lock,
        input  pll_rst, clkout0_gate, ready, fail, retry_cnt, loss_cnt, state
    );

endinterface

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: generic 2-flop synchroniser for asynchronous status inputs.
//   clk       destination clock
//   async_in  asynchronous input(s)
//   sync_out  input(s) delayed by two clk edges
// The flops deliberately carry no reset so nothing but the data path touches
// the metastability-prone first stage.
module pll_lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta     <= async_in;
        sync_out <= meta;
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: reset and lock sequencer for the DDR PLL wrapper.
// Holds the PLL in reset, waits for lock (retrying on timeout), requires lock
// to be stable before opening the clkout0 gate, then reports ready. Lock loss
// after the gate opens restarts the sequence and is counted.
//   clk   50 MHz reference clock (same net as PLL clkin1)
//   rst   synchronous, active-high reset
//   bus   pll_lock_ctrl_if.master: pll_lock in; pll_rst, clkout0_gate, ready,
//         fail, retry_cnt, loss_cnt, state out
// All outputs are registers decoded from the next state, so they change on
// the same edge as the state register. CNT_W must match the interface.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int GATE_DELAY   = DEF_GATE_DELAY,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    pll_lock_ctrl_if.master bus
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, GATE_DELAY);

    localparam logic [CW-1:0]    RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0]    GATE_LAST    = CW'(GATE_DELAY - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX    = CNT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] LOSS_SAT     = '1;

    logic             lock_s;
    pll_state_e       state;
    logic [CW-1:0]    cnt;
    pll_outs_t        outs_q;
    logic [CNT_W-1:0] retry_q;
    logic [CNT_W-1:0] loss_q;

    pll_lock_sync #(.WIDTH(1)) u_lock_sync (
        .clk      (clk),
        .async_in (bus.pll_lock),
        .sync_out (lock_s)
    );

    // Every transition loads the new state, clears cnt and loads that state's
    // outputs together; staying put just advances cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RST_HOLD;
            cnt     <= '0;
            outs_q  <= state_outs(RST_HOLD);
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                RST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        state  <= WAIT_LOCK;
                        cnt    <= '0;
                        outs_q <= state_outs(WAIT_LOCK);
                    end
                end

                WAIT_LOCK: begin
                    // Lock is tested first so a lock arriving on the timeout
                    // cycle wins over the retry.
                    if (lock_s) begin
                        state  <= STABLE;
                        cnt    <= '0;
                        outs_q <= state_outs(STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt <= '0;
                        if (retry_q == RETRY_MAX) begin
                            state  <= FAIL;
                            outs_q <= state_outs(FAIL);
                        end else begin
                            retry_q <= retry_q + 1'b1;
                            state   <= RST_HOLD;
                            outs_q  <= state_outs(RST_HOLD);
                        end
                    end
                end

                STABLE: begin
                    // A dropout here only restarts the wait; the PLL is not
                    // reset and no retry is charged.
                    if (!lock_s) begin
                        state  <= WAIT_LOCK;
                        cnt    <= '0;
                        outs_q <= state_outs(WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state  <= GATE_ON;
                        cnt    <= '0;
                        outs_q <= state_outs(GATE_ON);
                    end
                end

                GATE_ON, RUN: begin
                    if (!lock_s) begin
                        state  <= RST_HOLD;
                        cnt    <= '0;
                        outs_q <= state_outs(RST_HOLD);
                        if (loss_q != LOSS_SAT) begin
                            loss_q <= loss_q + 1'b1;
                        end
                    end else if (state == GATE_ON) begin
                        if (cnt == GATE_LAST) begin
                            state   <= RUN;
                            cnt     <= '0;
                            outs_q  <= state_outs(RUN);
                            retry_q <= '0;
                        end
                    end else begin
                        // RUN is open-ended; keep cnt parked.
                        cnt <= '0;
                    end
                end

                FAIL: begin
                    cnt <= '0;
                end

                default: begin
                    state  <= RST_HOLD;
                    cnt    <= '0;
                    outs_q <= state_outs(RST_HOLD);
                end
            endcase
        end
    end

    assign bus.pll_rst      = outs_q.pll_rst;
    assign bus.clkout0_gate = outs_q.clkout0_gate;
    assign bus.ready        = outs_q.ready;
    assign bus.fail         = outs_q.fail;
    assign bus.retry_cnt    = retry_q;
    assign bus.loss_cnt     = loss_q;
    assign bus.state        = state;

endmodule
